// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial bit-pattern detector.
// Detects patterns of 1..MAX_LEN bits in a qualified serial stream, with
// selectable overlapping / non-overlapping matching and a saturating
// match counter. The pattern is stored MSB-first: bit[len-1] is the first
// bit received and bit[0] the most recent one.
module seq_detect_prog #(
  parameter int                 MAX_LEN = 8,
  parameter logic [MAX_LEN-1:0] PATTERN = 8'b01101100,
  parameter int                 PAT_LEN = 7,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  parameter int                 LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seq,
  input  logic               seq_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               tick,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  // Active configuration
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;

  // Only the previous MAX_LEN-1 bits are stored; together with the bit
  // arriving this cycle they form the full MAX_LEN-bit comparison window.
  logic [MAX_LEN-2:0] hist_r;
  // Number of valid history bits counted towards the current search (0..len).
  logic [LEN_W-1:0]   fill_r;

  // Next-state helpers
  logic [MAX_LEN-1:0] nh_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               enough_s;
  logic               hit_s;
  logic               cfg_ok_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [LEN_W-1:0]   fill_inc_s;

  // Mask selecting the low 'len' bits of the comparison window.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  // Window formation, match decision, config validity and saturating updates.
  always_comb begin
    nh_s       = {hist_r, seq};
    mask_s     = len_mask(len_r);
    enough_s   = (({1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_r});
    hit_s      = enough_s && ((nh_s & mask_s) == (pat_r & mask_s));
    cfg_ok_s   = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_W'(MAX_LEN));
    if (match_cnt == {CNT_W{1'b1}}) begin
      cnt_inc_s = match_cnt;
    end else begin
      cnt_inc_s = match_cnt + CNT_W'(1);
    end
    if (fill_r >= len_r) begin
      fill_inc_s = len_r;
    end else begin
      fill_inc_s = fill_r + LEN_W'(1);
    end
  end

  // Detector state and registered outputs; priority rst > cfg_we > seq_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= PATTERN;
      len_r     <= LEN_W'(PAT_LEN);
      ovl_r     <= OVERLAP;
      hist_r    <= '0;
      fill_r    <= '0;
      tick      <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
    end else if (cfg_we) begin
      // The serial bit presented alongside a config write is dropped.
      if (cfg_ok_s) begin
        pat_r     <= cfg_pattern;
        len_r     <= cfg_len;
        ovl_r     <= cfg_overlap;
        hist_r    <= '0;
        fill_r    <= '0;
        match_cnt <= '0;
        tick      <= 1'b0;
        cfg_err   <= 1'b0;
      end else begin
        tick      <= 1'b0;
        cfg_err   <= 1'b1;
      end
    end else if (seq_valid) begin
      hist_r  <= nh_s[MAX_LEN-2:0];
      cfg_err <= 1'b0;
      if (hit_s) begin
        tick      <= 1'b1;
        match_cnt <= cnt_inc_s;
        // Non-overlapping mode restarts the search after every match.
        fill_r    <= ovl_r ? len_r : {LEN_W{1'b0}};
      end else begin
        tick      <= 1'b0;
        fill_r    <= fill_inc_s;
      end
    end else begin
      // Idle: partial matches survive gaps in seq_valid.
      tick    <= 1'b0;
      cfg_err <= 1'b0;
    end
  end

endmodule
